// File: rtl/write_back_register_file.sv
// Write side of the 32x32 integer register file.
// Write-back results enter a small in-order queue through a valid/ready
// handshake and drain into the storage array one entry per cycle. The read
// ports forward the youngest queued value for a register, so decode never
// observes a stale value while a write is still waiting in the queue.
module write_back_register_file #(
  parameter int WB_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            wb_ready_o,
  input  logic            drain_en_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic            valid_src1_i,
  input  logic            valid_src2_i,
  output logic [XLEN-1:0] val1_o,
  output logic [XLEN-1:0] val2_o,
  output logic            wb_pending_o
);

  // Pointer width covers WB_DEPTH entries; the count needs one extra bit so
  // that it can represent a completely full queue.
  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [XLEN-1:0] regs   [32];
  logic [4:0]      q_rd   [WB_DEPTH];
  logic [XLEN-1:0] q_data [WB_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push;
  logic            drain;

  // Ready looks only at registered occupancy: a full queue refuses even when
  // the head is draining in the same cycle. Writes to x0 finish the handshake
  // but never occupy a slot.
  assign wb_ready_o   = (count != CW'(WB_DEPTH));
  assign wb_pending_o = (count != '0);
  assign push         = wb_valid_i && wb_ready_o && (wb_rd_i != 5'd0);
  assign drain        = drain_en_i && (count != '0);

  // Queue bookkeeping: pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      case ({push, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload storage, written at the tail on every accepted push.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
    end else if (push) begin
      q_rd[tail]   <= wb_rd_i;
      q_data[tail] <= wb_data_i;
    end
  end

  // Architectural array: the queue head retires here when draining is enabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (drain && (q_rd[head] != 5'd0)) begin
      regs[q_rd[head]] <= q_data[head];
    end
  end

  // Read port 1: scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    val1_o = regs[rs1_i];
    for (int k = 0; k < WB_DEPTH; k++) begin
      if ((CW'(k) < count) && (q_rd[head + PW'(k)] == rs1_i)) begin
        val1_o = q_data[head + PW'(k)];
      end
    end
    if (!valid_src1_i || (rs1_i == 5'd0)) begin
      val1_o = '0;
    end
  end

  // Read port 2: same forwarding rule as port 1.
  always_comb begin
    val2_o = regs[rs2_i];
    for (int k = 0; k < WB_DEPTH; k++) begin
      if ((CW'(k) < count) && (q_rd[head + PW'(k)] == rs2_i)) begin
        val2_o = q_data[head + PW'(k)];
      end
    end
    if (!valid_src2_i || (rs2_i == 5'd0)) begin
      val2_o = '0;
    end
  end

endmodule

// File: tb/tb_write_back_register_file.sv
// Self-checking bench for write_back_register_file: a directed vector table,
// a hand-written reset-while-full sequence and a randomised phase checked
// against a small behavioural model through an expectation scoreboard.
module tb_write_back_register_file;

  localparam int WB_DEPTH = 2;
  localparam int XLEN     = 32;

  logic            clk_i;
  logic            rst_i;
  logic            wb_valid_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            wb_ready_o;
  logic            drain_en_i;
  logic [4:0]      rs1_i;
  logic [4:0]      rs2_i;
  logic            valid_src1_i;
  logic            valid_src2_i;
  logic [XLEN-1:0] val1_o;
  logic [XLEN-1:0] val2_o;
  logic            wb_pending_o;

  write_back_register_file #(.WB_DEPTH(WB_DEPTH), .XLEN(XLEN)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wb_valid_i   (wb_valid_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .wb_ready_o   (wb_ready_o),
    .drain_en_i   (drain_en_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .valid_src1_i (valid_src1_i),
    .valid_src2_i (valid_src2_i),
    .val1_o       (val1_o),
    .val2_o       (val2_o),
    .wb_pending_o (wb_pending_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic            valid;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            den;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            vs1;
    logic            vs2;
    logic [XLEN-1:0] exp1;
    logic [XLEN-1:0] exp2;
    logic            exp_rdy;
    logic            exp_pend;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] val1;
    logic [XLEN-1:0] val2;
    logic            rdy;
    logic            pend;
    int              step;
  } exp_t;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } qent_t;

  exp_t            sb[$];
  qent_t           m_q[$];
  logic [XLEN-1:0] m_regs [32];
  int              tests_run;
  int              tests_failed;
  int              step;

  // Compare one observed value against its expectation.
  task automatic compare(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL step %0d %s: got %h expected %h", step, name, got, want);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs now.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL step %0d scoreboard: got empty expected entry", step);
    end else begin
      e = sb.pop_front();
      compare("val1", val1_o, e.val1);
      compare("val2", val2_o, e.val2);
      compare("wb_ready", {31'd0, wb_ready_o}, {31'd0, e.rdy});
      compare("wb_pending", {31'd0, wb_pending_o}, {31'd0, e.pend});
    end
  endtask

  function automatic logic [XLEN-1:0] modelRead(input logic vs, input logic [4:0] rs);
    logic [XLEN-1:0] v;
    if (!vs || rs == 5'd0) return '0;
    v = m_regs[rs];
    foreach (m_q[i]) if (m_q[i].rd == rs) v = m_q[i].data;
    return v;
  endfunction

  task automatic modelReset();
    m_q.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  // Model state update for one rising edge, using the inputs currently driven.
  task automatic modelEdge();
    qent_t ent;
    logic  rdy;
    logic  pop;
    rdy = (m_q.size() != WB_DEPTH);
    pop = drain_en_i && (m_q.size() != 0);
    if (pop) begin
      ent = m_q.pop_front();
      m_regs[ent.rd] = ent.data;
    end
    if (wb_valid_i && rdy && wb_rd_i != 5'd0) begin
      ent.rd   = wb_rd_i;
      ent.data = wb_data_i;
      m_q.push_back(ent);
    end
  endtask

  function automatic exp_t modelExpect();
    exp_t e;
    e.val1 = modelRead(valid_src1_i, rs1_i);
    e.val2 = modelRead(valid_src2_i, rs2_i);
    e.rdy  = (m_q.size() != WB_DEPTH);
    e.pend = (m_q.size() != 0);
    e.step = step;
    return e;
  endfunction

  task automatic driveInputs(input vec_t v);
    wb_valid_i   = v.valid;
    wb_rd_i      = v.rd;
    wb_data_i    = v.data;
    drain_en_i   = v.den;
    rs1_i        = v.rs1;
    rs2_i        = v.rs2;
    valid_src1_i = v.vs1;
    valid_src2_i = v.vs2;
  endtask

  // One cycle from a table row: drive, check pre-edge outputs, clock, update model.
  task automatic applyStimulus(input vec_t v, input bit use_table);
    exp_t e;
    driveInputs(v);
    #1;
    if (use_table) begin
      e.val1 = v.exp1;
      e.val2 = v.exp2;
      e.rdy  = v.exp_rdy;
      e.pend = v.exp_pend;
      e.step = step;
    end else begin
      e = modelExpect();
    end
    sb.push_back(e);
    checkOutput();
    @(posedge clk_i);
    modelEdge();
    @(negedge clk_i);
    step++;
  endtask

  function automatic vec_t mk(input logic valid, input logic [4:0] rd, input logic [XLEN-1:0] data,
                              input logic den, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic vs1, input logic vs2, input logic [XLEN-1:0] exp1,
                              input logic [XLEN-1:0] exp2, input logic rdy, input logic pend);
    vec_t v;
    v.valid = valid; v.rd = rd; v.data = data; v.den = den;
    v.rs1 = rs1; v.rs2 = rs2; v.vs1 = vs1; v.vs2 = vs2;
    v.exp1 = exp1; v.exp2 = exp2; v.exp_rdy = rdy; v.exp_pend = pend;
    return v;
  endfunction

  vec_t tbl[$];
  vec_t rv;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    step         = 0;
    modelReset();
    rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    driveInputs(rv);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed rows: outputs are the values seen before the row's clock edge.
    tbl.push_back(mk(0, 0, 0,            0, 5, 31, 1, 1, 0,            0,            1, 0));
    tbl.push_back(mk(1, 3, 32'hDEADBEEF, 1, 3, 0,  1, 1, 0,            0,            1, 0));
    tbl.push_back(mk(0, 0, 0,            1, 3, 3,  1, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1));
    tbl.push_back(mk(0, 0, 0,            0, 3, 5,  1, 1, 32'hDEADBEEF, 0,            1, 0));
    tbl.push_back(mk(1, 7, 32'h11,       0, 7, 3,  1, 1, 0,            32'hDEADBEEF, 1, 0));
    tbl.push_back(mk(1, 7, 32'h22,       0, 7, 3,  1, 1, 32'h11,       32'hDEADBEEF, 1, 1));
    tbl.push_back(mk(1, 9, 32'h99,       1, 7, 9,  1, 1, 32'h22,       0,            0, 1));
    tbl.push_back(mk(1, 9, 32'h99,       1, 7, 9,  1, 1, 32'h22,       0,            1, 1));
    tbl.push_back(mk(0, 0, 0,            0, 7, 9,  1, 1, 32'h22,       32'h99,       1, 1));
    tbl.push_back(mk(0, 0, 0,            1, 9, 7,  1, 0, 32'h99,       0,            1, 1));
    tbl.push_back(mk(1, 0, 32'hFFFFFFFF, 1, 0, 9,  1, 1, 0,            32'h99,       1, 0));
    tbl.push_back(mk(0, 0, 0,            1, 0, 9,  1, 1, 0,            32'h99,       1, 0));
    tbl.push_back(mk(0, 0, 0,            0, 7, 3,  1, 1, 32'h22,       32'hDEADBEEF, 1, 0));
    foreach (tbl[i]) applyStimulus(tbl[i], 1'b1);

    // Fill the queue with two writes, then reset between edges.
    applyStimulus(mk(1, 4, 32'hAAAA, 0, 4, 5, 1, 1, 0, 0, 1, 0), 1'b1);
    applyStimulus(mk(1, 5, 32'hBBBB, 0, 4, 5, 1, 1, 32'hAAAA, 0, 1, 1), 1'b1);
    driveInputs(mk(0, 0, 0, 1, 4, 5, 1, 1, 0, 0, 1, 0));
    #1;
    sb.push_back('{val1: 32'hAAAA, val2: 32'hBBBB, rdy: 1'b0, pend: 1'b1, step: step});
    checkOutput();
    #1;
    rst_i = 1'b1;
    modelReset();
    #1;
    sb.push_back('{val1: '0, val2: '0, rdy: 1'b1, pend: 1'b0, step: step});
    checkOutput();
    @(negedge clk_i);
    rst_i = 1'b0;
    step++;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(0, 0, 0, 1, 4, 5, 1, 1, 0, 0, 1, 0), 1'b1);
    end
    applyStimulus(mk(0, 0, 0, 0, 3, 7, 1, 1, 0, 0, 1, 0), 1'b1);

    // Randomised traffic on a small register window, checked against the model.
    for (int i = 0; i < 300; i++) begin
      rv = mk($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), 0, 0, 0, 0);
      applyStimulus(rv, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
